// File: rtl/alu_shift_unit.sv
// Multi-cycle shift/rotate stage: loads an operand with its link flag, then
// performs one single-bit shift or rotate of {L,y} per clock.
module alu_shift_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [3:0]       count,
    input  logic [WIDTH-1:0] a,
    input  logic             lin,
    output logic [WIDTH-1:0] y,
    output logic             lout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] OP_SHL  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_ASR  = 3'b010;
    localparam logic [2:0] OP_ROLL = 3'b011;
    localparam logic [2:0] OP_RORL = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             l_q, l_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;

    logic [WIDTH-1:0] step_y;
    logic             step_l;
    logic [3:0]       eff_cnt;

    // One single-bit step of the latched operation on the current {L,y}.
    always_comb begin
        step_y = y_q;
        step_l = l_q;
        case (op_q)
            OP_SHL:  begin step_y = {y_q[WIDTH-2:0], 1'b0};      step_l = y_q[WIDTH-1]; end
            OP_SHR:  begin step_y = {1'b0, y_q[WIDTH-1:1]};      step_l = y_q[0];       end
            OP_ASR:  begin step_y = {y_q[WIDTH-1], y_q[WIDTH-1:1]}; step_l = y_q[0];    end
            OP_ROLL: begin step_y = {y_q[WIDTH-2:0], l_q};       step_l = y_q[WIDTH-1]; end
            OP_RORL: begin step_y = {l_q, y_q[WIDTH-1:1]};       step_l = y_q[0];       end
            OP_ROL:  step_y = {y_q[WIDTH-2:0], y_q[WIDTH-1]};
            OP_ROR:  step_y = {y_q[0], y_q[WIDTH-1:1]};
            default: ;
        endcase
    end

    // PASS is a zero-step load regardless of the requested count.
    assign eff_cnt = (op == OP_PASS) ? 4'd0 : count;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        l_d     = l_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    y_d     = a;
                    l_d     = lin;
                    op_d    = op;
                    cnt_d   = eff_cnt;
                    state_d = (eff_cnt == 4'd0) ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                y_d   = step_y;
                l_d   = step_l;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            y_q     <= '0;
            l_q     <= 1'b0;
            cnt_q   <= 4'd0;
            op_q    <= OP_SHL;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            l_q     <= l_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign y    = y_q;
    assign lout = l_q;
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_alu_shift_unit.sv
// Bench for alu_shift_unit: directed vector table, multi-cycle corner cases,
// and random operations checked against an arithmetic reference model.
module tb_alu_shift_unit;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start;
    logic [2:0]  op;
    logic [3:0]  count;
    logic [15:0] a;
    logic        lin;
    logic [15:0] y;
    logic        lout;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_shift_unit #(.WIDTH(16)) dut (
        .clk(clk), .nreset(nreset), .start(start), .op(op), .count(count),
        .a(a), .lin(lin), .y(y), .lout(lout), .busy(busy), .done(done)
    );

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  cnt;
        logic [15:0] a;
        logic        lin;
        logic [15:0] ey;
        logic        el;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {L,y} treated as plain integers, one step per iteration.
    function automatic logic [16:0] model(input logic [2:0] o, input logic [3:0] c,
                                          input logic [15:0] av, input logic li);
        int unsigned yv = av;
        int unsigned l  = li;
        int unsigned t;
        int n = (o == 3'd7) ? 0 : int'(c);
        for (int i = 0; i < n; i++) begin
            case (o)
                3'd0: begin l = yv / 32768; yv = (yv * 2) % 65536; end
                3'd1: begin l = yv % 2; yv = yv / 2; end
                3'd2: begin l = yv % 2; yv = yv / 2 + ((yv >= 32768) ? 32768 : 0); end
                3'd3: begin t = l; l = yv / 32768; yv = (yv * 2) % 65536 + t; end
                3'd4: begin t = l; l = yv % 2; yv = yv / 2 + t * 32768; end
                3'd5: yv = (yv * 2) % 65536 + yv / 32768;
                3'd6: yv = yv / 2 + (yv % 2) * 32768;
                default: ;
            endcase
        end
        model = {l[0], yv[15:0]};
    endfunction

    // Called at a negedge with the DUT ready to accept; returns at the done negedge.
    task automatic run_op(input string name, input logic [2:0] o, input logic [3:0] c,
                          input logic [15:0] av, input logic li,
                          input logic [15:0] ey, input logic el);
        int n = (o == 3'd7) ? 0 : int'(c);
        logic busy_ok = 1'b1;
        start = 1'b1; op = o; count = c; a = av; lin = li;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
        end
        @(negedge clk);
        chk({name, " busy window"}, {31'd0, busy_ok}, 32'd1);
        chk({name, " done/busy"}, {30'd0, done, busy}, 32'd2);
        chk({name, " y"}, {16'd0, y}, {16'd0, ey});
        chk({name, " lout"}, {31'd0, lout}, {31'd0, el});
    endtask

    task automatic idle_after(input string name, input logic [15:0] ey, input logic el);
        @(negedge clk);
        chk({name, " done pulse width"}, {30'd0, done, busy}, 32'd0);
        chk({name, " hold"}, {15'd0, lout, y}, {15'd0, el, ey});
    endtask

    initial begin
        logic [16:0] m;
        logic [2:0]  ro;
        logic [3:0]  rc;
        logic [15:0] ra;
        logic        rl;
        logic        seen;

        tbl[0]  = '{3'b000, 4'd1,  16'h8001, 1'b0, 16'h0002, 1'b1};
        tbl[1]  = '{3'b010, 4'd15, 16'h8000, 1'b0, 16'hFFFF, 1'b0};
        tbl[2]  = '{3'b011, 4'd1,  16'h8000, 1'b0, 16'h0000, 1'b1};
        tbl[3]  = '{3'b011, 4'd2,  16'h8000, 1'b0, 16'h0001, 1'b0};
        tbl[4]  = '{3'b110, 4'd4,  16'h0001, 1'b1, 16'h1000, 1'b1};
        tbl[5]  = '{3'b001, 4'd0,  16'h1234, 1'b1, 16'h1234, 1'b1};
        tbl[6]  = '{3'b111, 4'd9,  16'h1234, 1'b1, 16'h1234, 1'b1};
        tbl[7]  = '{3'b001, 4'd1,  16'h8001, 1'b0, 16'h4000, 1'b1};
        tbl[8]  = '{3'b100, 4'd1,  16'h0001, 1'b0, 16'h0000, 1'b1};
        tbl[9]  = '{3'b101, 4'd1,  16'h8001, 1'b0, 16'h0003, 1'b0};
        tbl[10] = '{3'b100, 4'd2,  16'h0003, 1'b1, 16'hC000, 1'b1};

        nreset = 1'b0; start = 1'b0; op = '0; count = '0; a = '0; lin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset state", {13'd0, done, busy, lout, y}, 32'd0);
        nreset = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy || y != 16'h0) seen = 1'b1;
        end
        chk("idle after reset", {31'd0, seen}, 32'd0);

        foreach (tbl[i]) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].cnt, tbl[i].a, tbl[i].lin,
                   tbl[i].ey, tbl[i].el);
            idle_after($sformatf("vec%0d", i), tbl[i].ey, tbl[i].el);
        end

        // start mid-SHIFT must be ignored
        start = 1'b1; op = 3'b000; count = 4'd8; a = 16'h00F1; lin = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; op = 3'b110; count = 4'd2; a = 16'hAAAA; lin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("ignored start busy", {30'd0, done, busy}, 32'd1);
        @(negedge clk);
        m = model(3'b000, 4'd8, 16'h00F1, 1'b0);
        chk("ignored start done", {30'd0, done, busy}, 32'd2);
        chk("ignored start result", {15'd0, lout, y}, {15'd0, m});
        idle_after("ignored start", m[15:0], m[16]);

        // start during DONE: back-to-back acceptance
        run_op("b2b first", 3'b000, 4'd3, 16'h0001, 1'b0, 16'h0008, 1'b0);
        run_op("b2b second", 3'b001, 4'd2, 16'h0010, 1'b1, 16'h0004, 1'b0);
        idle_after("b2b", 16'h0004, 1'b0);

        // asynchronous reset mid-SHIFT
        start = 1'b1; op = 3'b101; count = 4'd10; a = 16'h1357; lin = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #2 nreset = 1'b0;
        #1 chk("async reset", {13'd0, done, busy, lout, y}, 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("no done after abort", {31'd0, seen}, 32'd0);

        // random operations, sometimes back-to-back
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            rc = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rl = 1'($urandom);
            m  = model(ro, rc, ra, rl);
            run_op($sformatf("rand%0d", i), ro, rc, ra, rl, m[15:0], m[16]);
            if ($urandom_range(0, 1) == 1) idle_after($sformatf("rand%0d", i), m[15:0], m[16]);
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
